// File: rtl/mouse_grid_pkg.sv
// rtl/mouse_grid_pkg.sv - shared FSM encoding, default board geometry and width helper for the grid mapper
package mouse_grid_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        DONE  = 3'd4
    } grid_state_t;

    // Default board geometry, also used by the board-drawing modules
    localparam int DEF_GRID_COLS = 8;
    localparam int DEF_GRID_ROWS = 8;
    localparam int DEF_CELL_SIZE = 48;
    localparam int DEF_ORIGIN_X  = 256;
    localparam int DEF_ORIGIN_Y  = 128;

    // Index width for an axis of n cells, never narrower than one bit
    function automatic int axis_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mouse_grid_mapper_div.sv
// rtl/mouse_grid_mapper_div.sv - one-axis iterative subtract divider (grid_axis_div), one subtraction per cycle
module grid_axis_div #(
    parameter int CELL_SIZE = 48,
    parameter int QW        = 3,
    parameter int VW        = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [VW-1:0] operand_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quotient_o
);

    logic [VW-1:0] rem_q, rem_d;
    logic [QW-1:0] quo_q, quo_d;
    logic          busy_q, busy_d;
    logic          fits;

    assign fits       = (rem_q >= VW'(CELL_SIZE));
    // done is flagged in the cycle the remainder stops fitting, so a new start may overlap it
    assign done_o     = busy_q & ~fits;
    assign busy_o     = busy_q;
    assign quotient_o = quo_q;

    // Load on start, otherwise subtract one cell per cycle until the remainder is below a cell
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        busy_d = busy_q;
        if (start_i) begin
            rem_d  = operand_i;
            quo_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (fits) begin
                rem_d = rem_q - VW'(CELL_SIZE);
                quo_d = quo_q + 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/mouse_grid_mapper.sv
// rtl/mouse_grid_mapper.sv - cursor to board cell mapper with click events; optional MOUSE_GRID_DEBOUNCE_EN
module mouse_grid_mapper
    import mouse_grid_pkg::*;
#(
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int CELL_SIZE = DEF_CELL_SIZE,
    parameter int ORIGIN_X  = DEF_ORIGIN_X,
    parameter int ORIGIN_Y  = DEF_ORIGIN_Y
`ifdef MOUSE_GRID_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 65000
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          LMB,
    input  logic [11:0]                   mouse_xpos,
    input  logic [11:0]                   mouse_ypos,
    output logic [axis_w(GRID_COLS)-1:0]  cell_col,
    output logic [axis_w(GRID_ROWS)-1:0]  cell_row,
    output logic                          in_grid,
    output logic                          pos_valid,
    output logic                          place,
    output logic [axis_w(GRID_COLS)-1:0]  place_col,
    output logic [axis_w(GRID_ROWS)-1:0]  place_row,
    output logic                          place_miss
);

    localparam int CW     = axis_w(GRID_COLS);
    localparam int RW     = axis_w(GRID_ROWS);
    localparam int QW     = (CW > RW) ? CW : RW;
    localparam int GRID_W = GRID_COLS * CELL_SIZE;
    localparam int GRID_H = GRID_ROWS * CELL_SIZE;

    grid_state_t state_q, state_d;

    logic          lmb_meta_q, lmb_sync_q, lmb_prev_q, lmb_level, lmb_rise;
    logic          pending_q, pending_d, click_this_q, click_this_d;
    logic [12:0]   dx, dy, dy_q, dy_d;
    logic          off_grid;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] cell_col_q, cell_col_d, place_col_q, place_col_d;
    logic [RW-1:0] cell_row_q, cell_row_d, place_row_q, place_row_d;
    logic          in_grid_q, in_grid_d, pos_valid_q, pos_valid_d;
    logic          place_q, place_d, miss_q, miss_d;
    logic          div_start, div_busy, div_done;
    logic [12:0]   div_operand;
    logic [QW-1:0] div_quo;
    logic          fin, fin_in, fin_click;
    logic [CW-1:0] fin_col;
    logic [RW-1:0] fin_row;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lmb_meta_q <= 1'b0;
            lmb_sync_q <= 1'b0;
        end else begin
            lmb_meta_q <= LMB;
            lmb_sync_q <= lmb_meta_q;
        end
    end

`ifdef MOUSE_GRID_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_level_q;

    // Debounced level flips only after the synchronised level differs for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else if (lmb_sync_q == db_level_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q   <= '0;
            db_level_q <= lmb_sync_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end
    assign lmb_level = db_level_q;
`else
    assign lmb_level = lmb_sync_q;
`endif

    assign lmb_rise = lmb_level & ~lmb_prev_q;

    // Offsets from the board origin; bit 12 is the sign
    assign dx       = {1'b0, mouse_xpos} - 13'(ORIGIN_X);
    assign dy       = {1'b0, mouse_ypos} - 13'(ORIGIN_Y);
    assign off_grid = dx[12] | dy[12] | (dx >= 13'(GRID_W)) | (dy >= 13'(GRID_H));

    grid_axis_div #(
        .CELL_SIZE (CELL_SIZE),
        .QW        (QW),
        .VW        (13)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .operand_i  (div_operand),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Conversion FSM; results are registered on entry to DONE so pos_valid is high during DONE
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | lmb_rise;
        click_this_d = click_this_q;
        dy_d         = dy_q;
        col_d        = col_q;
        cell_col_d   = cell_col_q;
        cell_row_d   = cell_row_q;
        in_grid_d    = in_grid_q;
        place_col_d  = place_col_q;
        place_row_d  = place_row_q;
        pos_valid_d  = 1'b0;
        place_d      = 1'b0;
        miss_d       = 1'b0;
        div_start    = 1'b0;
        div_operand  = dx;
        fin          = 1'b0;
        fin_in       = 1'b0;
        fin_click    = 1'b0;
        fin_col      = '0;
        fin_row      = '0;
        case (state_q)
            IDLE: state_d = SNAP;
            SNAP: begin
                // An edge seen in this cycle stays pending for the next conversion
                pending_d    = lmb_rise;
                click_this_d = pending_q;
                dy_d         = dy;
                if (off_grid) begin
                    fin       = 1'b1;
                    fin_click = pending_q;
                    state_d   = DONE;
                end else begin
                    div_start   = 1'b1;
                    div_operand = dx;
                    state_d     = DIV_X;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    col_d       = div_quo[CW-1:0];
                    div_start   = 1'b1;
                    div_operand = dy_q;
                    state_d     = DIV_Y;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            DIV_Y: begin
                if (div_done) begin
                    fin       = 1'b1;
                    fin_in    = 1'b1;
                    fin_col   = col_q;
                    fin_row   = div_quo[RW-1:0];
                    fin_click = click_this_q;
                    state_d   = DONE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fin) begin
            cell_col_d  = fin_col;
            cell_row_d  = fin_row;
            in_grid_d   = fin_in;
            pos_valid_d = 1'b1;
            if (fin_click) begin
                if (fin_in) begin
                    place_d     = 1'b1;
                    place_col_d = fin_col;
                    place_row_d = fin_row;
                end else begin
                    miss_d = 1'b1;
                end
            end
        end
    end

    // State, click tracking and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lmb_prev_q   <= 1'b0;
            pending_q    <= 1'b0;
            click_this_q <= 1'b0;
            dy_q         <= '0;
            col_q        <= '0;
            cell_col_q   <= '0;
            cell_row_q   <= '0;
            in_grid_q    <= 1'b0;
            pos_valid_q  <= 1'b0;
            place_q      <= 1'b0;
            place_col_q  <= '0;
            place_row_q  <= '0;
            miss_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lmb_prev_q   <= lmb_level;
            pending_q    <= pending_d;
            click_this_q <= click_this_d;
            dy_q         <= dy_d;
            col_q        <= col_d;
            cell_col_q   <= cell_col_d;
            cell_row_q   <= cell_row_d;
            in_grid_q    <= in_grid_d;
            pos_valid_q  <= pos_valid_d;
            place_q      <= place_d;
            place_col_q  <= place_col_d;
            place_row_q  <= place_row_d;
            miss_q       <= miss_d;
        end
    end

    assign cell_col   = cell_col_q;
    assign cell_row   = cell_row_q;
    assign in_grid    = in_grid_q;
    assign pos_valid  = pos_valid_q;
    assign place      = place_q;
    assign place_col  = place_col_q;
    assign place_row  = place_row_q;
    assign place_miss = miss_q;

endmodule
